input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer.sv | 121 ++++++++++++
 tb/tb_input_debouncer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a bouncy asynchronous level; commits a change only after
// DEBOUNCE_CYCLES stable samples. Optional glitch counter under DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_i,
    output logic       data_o,
    output logic       busy_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // Bit 1 is the committed level, bit 0 marks a pending change.
    typedef enum logic [1:0] {
        StStableLow  = 2'b00,
        StRisePend   = 2'b01,
        StStableHigh = 2'b10,
        StFallPend   = 2'b11
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   glitch_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        glitch_evt = 1'b0;
        unique case (state_q)
            StStableLow: begin
                if (s) begin
                    state_d = StRisePend;
                    cnt_d   = CntW'(1);
                end
            end
            StRisePend: begin
                if (!s) begin
                    state_d    = StStableLow;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHigh;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStableHigh: begin
                if (!s) begin
                    state_d = StFallPend;
                    cnt_d   = CntW'(1);
                end
            end
            StFallPend: begin
                if (s) begin
                    state_d    = StStableHigh;
                    glitch_evt = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StStableLow;
            end
        endcase
    end

    // Outputs decode the state register only, so there is no path from raw_i or s.
    always_comb begin
        data_o = (state_q == StStableHigh) || (state_q == StFallPend);
        busy_o = (state_q == StRisePend) || (state_q == StFallPend);
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else if (glitch_evt && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt_o = glitch_q;
`else
    logic unused_glitch_evt;
    assign unused_glitch_evt = glitch_evt;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2) using a
// run-length model of the sampled input plus directed literal checks.
module tb_input_debouncer;

    localparam int unsigned DC   = 4;
    localparam int unsigned SYNC = 2;

    logic clk;
    logic reset;
    logic raw_i;
    logic data_o;
    logic busy_o;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_o;
`endif

    int n_checks;
    int n_fail;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_i       (raw_i),
        .data_o      (data_o),
        .busy_o      (busy_o)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt_o(glitch_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the level seen by the filter is raw_i delayed SYNC edges; the output flips when
    // that level has differed from it for DC samples in a row; a broken run is a glitch.
    logic [SYNC-1:0] m_hist;
    logic            m_data;
    int              m_run;
    int              m_glitch;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist   <= '0;
            m_data   <= 1'b0;
            m_run    <= 0;
            m_glitch <= 0;
        end else begin
            m_hist <= {m_hist[SYNC-2:0], raw_i};
            if (m_hist[SYNC-1] != m_data) begin
                if (m_run + 1 == int'(DC)) begin
                    m_data <= m_hist[SYNC-1];
                    m_run  <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch <= m_glitch + 1;
                m_run <= 0;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("model_data", int'(data_o), int'(m_data));
            check("model_busy", int'(busy_o), (m_run > 0) ? 1 : 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            check("model_glitch", int'(glitch_cnt_o), m_glitch);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic exp_data, input logic exp_busy);
        check({name, "_data"}, int'(data_o), int'(exp_data));
        check({name, "_busy"}, int'(busy_o), int'(exp_busy));
    endtask

    task automatic lit_glitch(input string name, input int exp_cnt);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check(name, int'(glitch_cnt_o), exp_cnt);
`else
        if (exp_cnt < 0) $display("unexpected glitch expectation %0d for %s", exp_cnt, name);
`endif
    endtask

    logic [8:0] bounce;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        raw_i    = 1'b1;
        reset    = 1'b1;

        // Reset held with raw high: outputs stay cleared.
        #2;
        lit("reset_hold0", 1'b0, 1'b0);
        lit_glitch("reset_glitch", 0);
        step(4);
        lit("reset_hold1", 1'b0, 1'b0);
        raw_i = 1'b0;
        step(1);
        reset = 1'b0;
        step(4);
        lit("idle", 1'b0, 1'b0);

        // Clean rise then clean fall.
        raw_i = 1'b1;
        step(2);
        lit("rise_e2", 1'b0, 1'b0);
        step(1);
        lit("rise_e3", 1'b0, 1'b1);
        step(2);
        lit("rise_e5", 1'b0, 1'b1);
        step(1);
        lit("rise_e6", 1'b1, 1'b0);
        step(3);
        raw_i = 1'b0;
        step(3);
        lit("fall_e3", 1'b1, 1'b1);
        step(2);
        lit("fall_e5", 1'b1, 1'b1);
        step(1);
        lit("fall_e6", 1'b0, 1'b0);
        lit_glitch("clean_glitch", 0);
        step(3);

        // Three-edge pulse: busy for three cycles, then rejected.
        raw_i = 1'b1;
        step(3);
        raw_i = 1'b0;
        step(2);
        lit("short_e5", 1'b0, 1'b1);
        step(1);
        lit("short_e6", 1'b0, 1'b0);
        lit_glitch("short_glitch", 1);
        step(4);

        // Bounce 1,0,1,1,0,1,1,1,1 then held high: commits on edge 11.
        bounce = 9'b1_1110_1101;
        for (int i = 0; i < 9; i++) begin
            raw_i = bounce[i];
            step(1);
        end
        step(1);
        lit("bounce_e10", 1'b0, 1'b1);
        step(1);
        lit("bounce_e11", 1'b1, 1'b0);
        lit_glitch("bounce_glitch", 3);
        raw_i = 1'b0;
        step(8);
        lit("bounce_low", 1'b0, 1'b0);

        // Reset mid-qualification abandons it; restart after release.
        raw_i = 1'b1;
        step(5);
        lit("abort_pend", 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        lit("abort_async", 1'b0, 1'b0);
        lit_glitch("abort_glitch", 0);
        step(2);
        lit("abort_held", 1'b0, 1'b0);
        reset = 1'b0;
        step(5);
        lit("restart_e5", 1'b0, 1'b1);
        step(1);
        lit("restart_e6", 1'b1, 1'b0);
        raw_i = 1'b0;
        step(7);
        lit("restart_low", 1'b0, 1'b0);

        // 300 two-edge glitches saturate the counter; output never moves.
        for (int i = 0; i < 300; i++) begin
            raw_i = 1'b1;
            step(2);
            raw_i = 1'b0;
            step(2);
        end
        step(3);
        lit("sat_end", 1'b0, 1'b0);
        lit_glitch("sat_glitch", 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
